// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: hands out tags at decode, collects CDB results,
// and retires the head entry to the RegFile write port, raising a flush on a mispredicted commit.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic              alloc_wen,
    input  logic [4:0]        alloc_drindex,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_roben,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_roben,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispredict,
    input  logic [TAG_W-1:0]  rd1_roben,
    output logic              rd1_ready,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [TAG_W-1:0]  rd2_roben,
    output logic              rd2_ready,
    output logic [DATA_W-1:0] rd2_data,
    output logic              WP1_Wen,
    output logic [TAG_W-1:0]  WP1_ROBEN,
    output logic [4:0]        WP1_DRindex,
    output logic [DATA_W-1:0] WP1_Data,
    output logic              ROB_FLUSH_Flag,
    output logic [TAG_W:0]    count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [TAG_W-1:0] MAX_TAG    = TAG_W'(DEPTH);

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  ready;
    logic [DEPTH-1:0]  wen;
    logic [DEPTH-1:0]  mispredict;
    logic [4:0]        drindex [DEPTH];
    logic [DATA_W-1:0] data    [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic             commit;
    logic             flush;
    logic             do_alloc;
    logic             cdb_hit;
    logic [PTR_W-1:0] cdb_idx;

    // Tags are slot+1, so tag 0 and tags beyond DEPTH never name an entry.
    function automatic logic tag_valid(input logic [TAG_W-1:0] tag);
        return (tag != '0) && (tag <= MAX_TAG);
    endfunction

    function automatic logic [PTR_W-1:0] tag_index(input logic [TAG_W-1:0] tag);
        return PTR_W'(tag - TAG_W'(1));
    endfunction

    function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] tag);
        logic [PTR_W-1:0] idx;
        idx = tag_index(tag);
        if (cdb_valid && (tag != '0) && (cdb_roben == tag))
            return {1'b1, cdb_data};
        else if (tag_valid(tag) && busy[idx] && ready[idx])
            return {1'b1, data[idx]};
        return '0;
    endfunction

    assign commit         = busy[head] & ready[head];
    assign flush          = commit & mispredict[head];
    assign ROB_FLUSH_Flag = flush;

    // A slot freed by this cycle's commit only becomes allocatable next cycle.
    assign alloc_ready = (count != FULL_COUNT) & ~flush;
    assign alloc_roben = TAG_W'(tail) + TAG_W'(1);
    assign do_alloc    = alloc_valid & alloc_ready;

    assign cdb_idx = tag_index(cdb_roben);
    assign cdb_hit = cdb_valid & tag_valid(cdb_roben) & busy[cdb_idx];

    assign WP1_Wen     = commit & wen[head] & (drindex[head] != 5'd0);
    assign WP1_ROBEN   = commit ? (TAG_W'(head) + TAG_W'(1)) : '0;
    assign WP1_DRindex = commit ? drindex[head] : 5'd0;
    assign WP1_Data    = commit ? data[head] : '0;

    always_comb begin
        {rd1_ready, rd1_data} = lookup(rd1_roben);
        {rd2_ready, rd2_data} = lookup(rd2_roben);
    end

    // Ordering matters: CDB, then commit clear, then allocation, so the last write wins.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy       <= '0;
            ready      <= '0;
            wen        <= '0;
            mispredict <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            if (cdb_hit) begin
                ready[cdb_idx]      <= 1'b1;
                mispredict[cdb_idx] <= cdb_mispredict;
            end
            if (commit) begin
                busy[head]       <= 1'b0;
                ready[head]      <= 1'b0;
                mispredict[head] <= 1'b0;
                head             <= head + PTR_W'(1);
            end
            if (do_alloc) begin
                busy[tail]       <= 1'b1;
                ready[tail]      <= 1'b0;
                wen[tail]        <= alloc_wen;
                mispredict[tail] <= 1'b0;
                tail             <= tail + PTR_W'(1);
            end
            case ({do_alloc, commit})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through busy/ready-qualified paths.
    always_ff @(posedge clk) begin
        if (cdb_hit)
            data[cdb_idx] <= cdb_data;
        if (do_alloc)
            drindex[tail] <= alloc_drindex;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based program-order model.
module tb_reorder_buffer;
    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_wen;
    logic [4:0]  alloc_drindex;
    logic        alloc_ready;
    logic [4:0]  alloc_roben;
    logic        cdb_valid;
    logic [4:0]  cdb_roben;
    logic [31:0] cdb_data;
    logic        cdb_mispredict;
    logic [4:0]  rd1_roben;
    logic        rd1_ready;
    logic [31:0] rd1_data;
    logic [4:0]  rd2_roben;
    logic        rd2_ready;
    logic [31:0] rd2_data;
    logic        WP1_Wen;
    logic [4:0]  WP1_ROBEN;
    logic [4:0]  WP1_DRindex;
    logic [31:0] WP1_Data;
    logic        ROB_FLUSH_Flag;
    logic [5:0]  count;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    reorder_buffer #(.DEPTH(16), .TAG_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_wen(alloc_wen), .alloc_drindex(alloc_drindex),
        .alloc_ready(alloc_ready), .alloc_roben(alloc_roben),
        .cdb_valid(cdb_valid), .cdb_roben(cdb_roben), .cdb_data(cdb_data),
        .cdb_mispredict(cdb_mispredict),
        .rd1_roben(rd1_roben), .rd1_ready(rd1_ready), .rd1_data(rd1_data),
        .rd2_roben(rd2_roben), .rd2_ready(rd2_ready), .rd2_data(rd2_data),
        .WP1_Wen(WP1_Wen), .WP1_ROBEN(WP1_ROBEN), .WP1_DRindex(WP1_DRindex),
        .WP1_Data(WP1_Data), .ROB_FLUSH_Flag(ROB_FLUSH_Flag), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program-order model: the queue front is the oldest in-flight instruction.
    typedef struct {
        logic [4:0]  tag;
        bit          wen;
        logic [4:0]  rd;
        bit          rdy;
        logic [31:0] data;
        bit          mis;
    } ent_t;

    ent_t q[$];
    int   next_tag = 1;

    function automatic bit m_commit();
        return (q.size() > 0) && q[0].rdy;
    endfunction

    function automatic bit m_flush();
        return m_commit() && q[0].mis;
    endfunction

    function automatic bit m_alloc_ready();
        return (q.size() != 16) && !m_flush();
    endfunction

    function automatic logic [32:0] m_lookup(input logic [4:0] tag);
        if (tag == 5'd0) return 33'd0;
        if (cdb_valid && cdb_roben == tag) return {1'b1, cdb_data};
        foreach (q[i])
            if (q[i].tag == tag)
                return q[i].rdy ? {1'b1, q[i].data} : 33'd0;
        return 33'd0;
    endfunction

    task automatic model_update();
        bit c;
        bit f;
        bit ar;
        ent_t e;
        c  = m_commit();
        f  = m_flush();
        ar = m_alloc_ready();
        if (rst || f) begin
            q.delete();
            next_tag = 1;
        end else begin
            if (cdb_valid) begin
                foreach (q[i]) begin
                    if (q[i].tag == cdb_roben) begin
                        e      = q[i];
                        e.rdy  = 1'b1;
                        e.data = cdb_data;
                        e.mis  = cdb_mispredict;
                        q[i]   = e;
                    end
                end
            end
            if (c) void'(q.pop_front());
            if (alloc_valid && ar) begin
                e.tag  = 5'(next_tag);
                e.wen  = alloc_wen;
                e.rd   = alloc_drindex;
                e.rdy  = 1'b0;
                e.data = 32'd0;
                e.mis  = 1'b0;
                q.push_back(e);
                next_tag = (next_tag == 16) ? 1 : next_tag + 1;
            end
        end
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit c;
        logic [32:0] l1;
        logic [32:0] l2;
        c  = m_commit();
        l1 = m_lookup(rd1_roben);
        l2 = m_lookup(rd2_roben);
        check_output("alloc_ready", 64'(alloc_ready), 64'(m_alloc_ready()));
        check_output("alloc_roben", 64'(alloc_roben), 64'(next_tag));
        check_output("count", 64'(count), 64'(q.size()));
        check_output("flush", 64'(ROB_FLUSH_Flag), 64'(m_flush()));
        check_output("wp1_wen", 64'(WP1_Wen), 64'(c && q[0].wen && q[0].rd != 5'd0));
        check_output("wp1_roben", 64'(WP1_ROBEN), c ? 64'(q[0].tag) : 64'd0);
        check_output("wp1_drindex", 64'(WP1_DRindex), c ? 64'(q[0].rd) : 64'd0);
        check_output("wp1_data", 64'(WP1_Data), c ? 64'(q[0].data) : 64'd0);
        check_output("rd1", 64'({rd1_ready, rd1_data}), 64'(l1));
        check_output("rd2", 64'({rd2_ready, rd2_data}), 64'(l2));
    endtask

    always @(posedge clk) model_update();

    always @(negedge clk) begin
        #2;
        if (check_en) compare_all();
    end

    // Advance to the next cycle's drive point with all inputs idle.
    task automatic apply_stimulus();
        @(negedge clk);
        rst            = 1'b0;
        alloc_valid    = 1'b0;
        alloc_wen      = 1'b0;
        alloc_drindex  = 5'd0;
        cdb_valid      = 1'b0;
        cdb_roben      = 5'd0;
        cdb_data       = 32'd0;
        cdb_mispredict = 1'b0;
        rd1_roben      = 5'd0;
        rd2_roben      = 5'd0;
    endtask

    task automatic alloc_n(input int n, input bit w, input logic [4:0] rd0);
        for (int i = 0; i < n; i++) begin
            apply_stimulus();
            alloc_valid   = 1'b1;
            alloc_wen     = w;
            alloc_drindex = rd0 + 5'(i);
        end
    endtask

    task automatic do_reset();
        apply_stimulus();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; alloc_valid = 0; alloc_wen = 0; alloc_drindex = 0;
        cdb_valid = 0; cdb_roben = 0; cdb_data = 0; cdb_mispredict = 0;
        rd1_roben = 0; rd2_roben = 0;
        repeat (2) @(posedge clk);
        check_en = 1;

        // T1: reset state, then three allocations
        apply_stimulus(); #3;
        check_output("t1_reset_alloc_ready", 64'(alloc_ready), 64'd1);
        check_output("t1_reset_alloc_roben", 64'(alloc_roben), 64'd1);
        check_output("t1_reset_count", 64'(count), 64'd0);
        check_output("t1_reset_wen", 64'(WP1_Wen), 64'd0);
        check_output("t1_reset_flush", 64'(ROB_FLUSH_Flag), 64'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            alloc_valid = 1; alloc_wen = 1; alloc_drindex = 5'(5 + i);
            #3 check_output("t1_alloc_roben", 64'(alloc_roben), 64'(i + 1));
        end
        apply_stimulus(); #3;
        check_output("t1_count", 64'(count), 64'd3);
        check_output("t1_no_commit", 64'(WP1_Wen), 64'd0);

        // T2: out-of-order completion, in-order retirement
        apply_stimulus(); cdb_valid = 1; cdb_roben = 2; cdb_data = 32'hAA;
        #3 check_output("t2_wait_head", 64'(WP1_Wen), 64'd0);
        apply_stimulus(); cdb_valid = 1; cdb_roben = 1; cdb_data = 32'h55;
        apply_stimulus(); #3;
        check_output("t2_c1_wen", 64'(WP1_Wen), 64'd1);
        check_output("t2_c1_roben", 64'(WP1_ROBEN), 64'd1);
        check_output("t2_c1_rd", 64'(WP1_DRindex), 64'd5);
        check_output("t2_c1_data", 64'(WP1_Data), 64'h55);
        apply_stimulus(); #3;
        check_output("t2_c2_roben", 64'(WP1_ROBEN), 64'd2);
        check_output("t2_c2_rd", 64'(WP1_DRindex), 64'd6);
        check_output("t2_c2_data", 64'(WP1_Data), 64'hAA);
        check_output("t2_count", 64'(count), 64'd2);
        apply_stimulus(); #3 check_output("t2_count_after", 64'(count), 64'd1);

        // T3: fill, overflow attempt, wrap of the tag
        do_reset();
        alloc_n(16, 1'b1, 5'd1);
        apply_stimulus(); alloc_valid = 1; alloc_wen = 1; alloc_drindex = 5'd30;
        cdb_valid = 1; cdb_roben = 1; cdb_data = 32'h100;
        #3;
        check_output("t3_full_ready", 64'(alloc_ready), 64'd0);
        check_output("t3_full_count", 64'(count), 64'd16);
        apply_stimulus(); #3;
        check_output("t3_commit_roben", 64'(WP1_ROBEN), 64'd1);
        check_output("t3_commit_no_free", 64'(alloc_ready), 64'd0);
        check_output("t3_count_17th_ignored", 64'(count), 64'd16);
        apply_stimulus(); alloc_valid = 1; alloc_wen = 1; alloc_drindex = 5'd9;
        #3;
        check_output("t3_wrap_ready", 64'(alloc_ready), 64'd1);
        check_output("t3_wrap_roben", 64'(alloc_roben), 64'd1);
        apply_stimulus(); #3 check_output("t3_refull", 64'(count), 64'd16);

        // T4: mispredicted branch at head flushes younger entries
        do_reset();
        alloc_n(1, 1'b0, 5'd0);
        alloc_n(3, 1'b1, 5'd10);
        apply_stimulus(); cdb_valid = 1; cdb_roben = 1; cdb_data = 32'hDEAD; cdb_mispredict = 1;
        apply_stimulus(); alloc_valid = 1; alloc_wen = 1; alloc_drindex = 5'd3;
        cdb_valid = 1; cdb_roben = 2; cdb_data = 32'h22;
        #3;
        check_output("t4_flush", 64'(ROB_FLUSH_Flag), 64'd1);
        check_output("t4_branch_nowrite", 64'(WP1_Wen), 64'd0);
        check_output("t4_alloc_blocked", 64'(alloc_ready), 64'd0);
        apply_stimulus(); cdb_valid = 1; cdb_roben = 3; cdb_data = 32'h77;
        #3;
        check_output("t4_flush_pulse", 64'(ROB_FLUSH_Flag), 64'd0);
        check_output("t4_count", 64'(count), 64'd0);
        check_output("t4_roben", 64'(alloc_roben), 64'd1);
        apply_stimulus(); rd1_roben = 3;
        #3 check_output("t4_stale_cdb", 64'(rd1_ready), 64'd0);

        // T5: CDB bypass on the lookup port
        alloc_n(4, 1'b1, 5'd20);
        apply_stimulus(); cdb_valid = 1; cdb_roben = 4; cdb_data = 32'h1234; rd1_roben = 4;
        #3;
        check_output("t5_bypass_ready", 64'(rd1_ready), 64'd1);
        check_output("t5_bypass_data", 64'(rd1_data), 64'h1234);
        apply_stimulus(); rd1_roben = 4; rd2_roben = 2;
        #3;
        check_output("t5_stored_data", 64'(rd1_data), 64'h1234);
        check_output("t5_not_ready", 64'(rd2_ready), 64'd0);

        // T6: reset mid-stream
        alloc_n(4, 1'b1, 5'd24);
        apply_stimulus(); cdb_valid = 1; cdb_roben = 1; cdb_data = 32'h11;
        apply_stimulus(); rst = 1;
        #3 check_output("t6_pre_reset_count", 64'(count), 64'd8);
        apply_stimulus(); #3;
        check_output("t6_count", 64'(count), 64'd0);
        check_output("t6_wen", 64'(WP1_Wen), 64'd0);
        check_output("t6_roben", 64'(alloc_roben), 64'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            apply_stimulus();
            rst           = ($urandom_range(299) == 0);
            alloc_valid   = ($urandom_range(3) != 0);
            alloc_wen     = $urandom_range(1) == 1;
            alloc_drindex = 5'($urandom_range(31));
            cdb_valid     = ($urandom_range(9) < 6);
            if (q.size() > 0 && $urandom_range(7) != 0)
                cdb_roben = q[$urandom_range(q.size() - 1)].tag;
            else
                cdb_roben = 5'($urandom_range(31));
            cdb_data       = $urandom;
            cdb_mispredict = ($urandom_range(24) == 0);
            if ($urandom_range(3) == 0)
                rd1_roben = cdb_roben;
            else if (q.size() > 0)
                rd1_roben = q[$urandom_range(q.size() - 1)].tag;
            else
                rd1_roben = 5'($urandom_range(20));
            rd2_roben = 5'($urandom_range(20));
        end

        apply_stimulus();
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
